// File: rtl/tgen_divider.sv
`default_nettype none
// ============================================================================
//  Module      : tgen_divider
//  Description : Programmable divide-by-N toggle-enable generator. Produces a
//                one-cycle t_pulse every N falling edges while running, an
//                internal divide-by-2N square wave (q_div) and a modulo-256
//                pulse counter. IDLE / RUN / PAUSE control with load priority.
//  Revision    : 1.0 - initial release
// ============================================================================
module tgen_divider #(
    parameter int WIDTH   = 8,
    parameter int DEF_DIV = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] div_val,
    output logic             t_pulse,
    output logic             q_div,
    output logic [WIDTH-1:0] cnt,
    output logic [7:0]       pulse_cnt,
    output logic             busy
);

    // ------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_PAUSE = 2'd2;

    localparam logic [WIDTH-1:0] C_ONE     = WIDTH'(1);
    localparam logic [WIDTH-1:0] C_DEF_DIV = WIDTH'(DEF_DIV);

    logic [1:0]       state_q,     state_d;
    logic [WIDTH-1:0] per_q,       per_d;
    logic [WIDTH-1:0] cnt_q,       cnt_d;
    logic             t_pulse_q,   t_pulse_d;
    logic             q_div_q,     q_div_d;
    logic [7:0]       pulse_cnt_q, pulse_cnt_d;
    logic [WIDTH-1:0] term;
    logic             at_term;

    // Terminal count: ratios 0 and 1 both collapse to a pulse every cycle.
    always_comb begin
        term    = (per_q <= C_ONE) ? '0 : (per_q - C_ONE);
        at_term = (cnt_q == term);
    end

    // Next-state logic: load wins over everything, then en gates counting.
    // A counting edge is any edge with en=1 (including the IDLE->RUN and
    // PAUSE->RUN edges), so a paused period resumes with no phase loss and
    // the period always spans exactly max(N,1) counting edges.
    always_comb begin
        state_d     = state_q;
        per_d       = per_q;
        cnt_d       = cnt_q;
        t_pulse_d   = 1'b0;
        q_div_d     = q_div_q;
        pulse_cnt_d = pulse_cnt_q;

        if (load) begin
            // Abort the current period; no pulse even if cnt==term.
            per_d   = div_val;
            cnt_d   = '0;
            state_d = en ? S_RUN : S_IDLE;
        end else if (en) begin
            state_d = S_RUN;
            if (at_term) begin
                cnt_d       = '0;
                t_pulse_d   = 1'b1;
                q_div_d     = ~q_div_q;
                pulse_cnt_d = pulse_cnt_q + 8'd1;
            end else begin
                cnt_d = cnt_q + C_ONE;
            end
        end else begin
            case (state_q)
                S_IDLE:  state_d = S_IDLE;
                S_RUN:   state_d = S_PAUSE;
                S_PAUSE: state_d = S_PAUSE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // State registers update on the falling edge; reset is asynchronous.
    always_ff @(negedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            per_q       <= C_DEF_DIV;
            cnt_q       <= '0;
            t_pulse_q   <= 1'b0;
            q_div_q     <= 1'b0;
            pulse_cnt_q <= 8'd0;
        end else begin
            state_q     <= state_d;
            per_q       <= per_d;
            cnt_q       <= cnt_d;
            t_pulse_q   <= t_pulse_d;
            q_div_q     <= q_div_d;
            pulse_cnt_q <= pulse_cnt_d;
        end
    end

    // Outputs come straight from registers; busy decodes the state only.
    assign t_pulse   = t_pulse_q;
    assign q_div     = q_div_q;
    assign cnt       = cnt_q;
    assign pulse_cnt = pulse_cnt_q;
    assign busy      = (state_q == S_RUN);

endmodule
`default_nettype wire

// File: tb/tb_tgen_divider.sv
`default_nettype none
// ============================================================================
//  Module      : tb_tgen_divider
//  Description : Directed, table-driven testbench for tgen_divider.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_tgen_divider;

    logic       clk;
    logic       reset;
    logic       en;
    logic       load;
    logic [7:0] div_val;
    logic       t_pulse;
    logic       q_div;
    logic [7:0] cnt;
    logic [7:0] pulse_cnt;
    logic       busy;

    int n_checks = 0;
    int n_errors = 0;

    tgen_divider #(
        .WIDTH   (8),
        .DEF_DIV (2)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .en        (en),
        .load      (load),
        .div_val   (div_val),
        .t_pulse   (t_pulse),
        .q_div     (q_div),
        .cnt       (cnt),
        .pulse_cnt (pulse_cnt),
        .busy      (busy)
    );

    // Falling edges at 5, 15, 25, ...
    initial clk = 1'b1;
    always #5 clk = ~clk;

    typedef struct {
        logic       ld;
        logic       en;
        logic [7:0] div;
        logic       t;
        logic       q;
        logic [7:0] cnt;
        logic       busy;
        logic [7:0] pc;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic ld, input logic e, input int dv,
                                input logic t, input logic q, input int c,
                                input logic b, input int pc);
        vec_t v;
        v.ld   = ld;
        v.en   = e;
        v.div  = 8'(dv);
        v.t    = t;
        v.q    = q;
        v.cnt  = 8'(c);
        v.busy = b;
        v.pc   = 8'(pc);
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic chk_all(input string tag, input vec_t v);
        chk({tag, " t_pulse"},   int'(t_pulse),   int'(v.t));
        chk({tag, " q_div"},     int'(q_div),     int'(v.q));
        chk({tag, " cnt"},       int'(cnt),       int'(v.cnt));
        chk({tag, " busy"},      int'(busy),      int'(v.busy));
        chk({tag, " pulse_cnt"}, int'(pulse_cnt), int'(v.pc));
    endtask

    // Safety net so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic exp_q;
        //          ld en div  t  q cnt busy pc
        // Reset release with en=1, default ratio 2: pulses on edges 2,4,6
        vecs.push_back(mk(0, 1, 0, 0, 0, 1, 1, 0));
        vecs.push_back(mk(0, 1, 0, 1, 1, 0, 1, 1));
        vecs.push_back(mk(0, 1, 0, 0, 1, 1, 1, 1));
        vecs.push_back(mk(0, 1, 0, 1, 0, 0, 1, 2));
        vecs.push_back(mk(0, 1, 0, 0, 0, 1, 1, 2));
        vecs.push_back(mk(0, 1, 0, 1, 1, 0, 1, 3));
        // Load N=5: pulse 5 edges after load, then every 5
        vecs.push_back(mk(1, 1, 5, 0, 1, 0, 1, 3));
        vecs.push_back(mk(0, 1, 0, 0, 1, 1, 1, 3));
        vecs.push_back(mk(0, 1, 0, 0, 1, 2, 1, 3));
        vecs.push_back(mk(0, 1, 0, 0, 1, 3, 1, 3));
        vecs.push_back(mk(0, 1, 0, 0, 1, 4, 1, 3));
        vecs.push_back(mk(0, 1, 0, 1, 0, 0, 1, 4));
        vecs.push_back(mk(0, 1, 0, 0, 0, 1, 1, 4));
        vecs.push_back(mk(0, 1, 0, 0, 0, 2, 1, 4));
        vecs.push_back(mk(0, 1, 0, 0, 0, 3, 1, 4));
        vecs.push_back(mk(0, 1, 0, 0, 0, 4, 1, 4));
        vecs.push_back(mk(0, 1, 0, 1, 1, 0, 1, 5));
        // Load N=0: pulse every cycle
        vecs.push_back(mk(1, 1, 0, 0, 1, 0, 1, 5));
        vecs.push_back(mk(0, 1, 0, 1, 0, 0, 1, 6));
        vecs.push_back(mk(0, 1, 0, 1, 1, 0, 1, 7));
        vecs.push_back(mk(0, 1, 0, 1, 0, 0, 1, 8));
        // Load N=1: pulse every cycle
        vecs.push_back(mk(1, 1, 1, 0, 0, 0, 1, 8));
        vecs.push_back(mk(0, 1, 0, 1, 1, 0, 1, 9));
        vecs.push_back(mk(0, 1, 0, 1, 0, 0, 1, 10));
        // Load N=4, pause 3 cycles at cnt=2, resume: pulse 2 edges later
        vecs.push_back(mk(1, 1, 4, 0, 0, 0, 1, 10));
        vecs.push_back(mk(0, 1, 0, 0, 0, 1, 1, 10));
        vecs.push_back(mk(0, 1, 0, 0, 0, 2, 1, 10));
        vecs.push_back(mk(0, 0, 0, 0, 0, 2, 0, 10));
        vecs.push_back(mk(0, 0, 0, 0, 0, 2, 0, 10));
        vecs.push_back(mk(0, 0, 0, 0, 0, 2, 0, 10));
        vecs.push_back(mk(0, 1, 0, 0, 0, 3, 1, 10));
        vecs.push_back(mk(0, 1, 0, 1, 1, 0, 1, 11));
        vecs.push_back(mk(0, 1, 0, 0, 1, 1, 1, 11));
        // Load N=3 with en=0 -> IDLE, then start
        vecs.push_back(mk(1, 0, 3, 0, 1, 0, 0, 11));
        vecs.push_back(mk(0, 0, 0, 0, 1, 0, 0, 11));
        vecs.push_back(mk(0, 1, 0, 0, 1, 1, 1, 11));
        vecs.push_back(mk(0, 1, 0, 0, 1, 2, 1, 11));
        vecs.push_back(mk(0, 1, 0, 1, 0, 0, 1, 12));
        vecs.push_back(mk(0, 1, 0, 0, 0, 1, 1, 12));
        vecs.push_back(mk(0, 1, 0, 0, 0, 2, 1, 12));
        // Load while cnt==term: period aborted, no pulse on the load edge
        vecs.push_back(mk(1, 1, 3, 0, 0, 0, 1, 12));
        vecs.push_back(mk(0, 1, 0, 0, 0, 1, 1, 12));
        vecs.push_back(mk(0, 1, 0, 0, 0, 2, 1, 12));
        vecs.push_back(mk(0, 1, 0, 1, 1, 0, 1, 13));

        // ---------------- reset state ----------------
        reset   = 1'b0;
        en      = 1'b0;
        load    = 1'b0;
        div_val = 8'd0;
        #1 reset = 1'b1;
        #1;
        chk_all("reset_async", mk(0, 0, 0, 0, 0, 0, 0, 0));
        step();
        step();
        chk_all("reset_held", mk(0, 0, 0, 0, 0, 0, 0, 0));
        reset = 1'b0;

        // ---------------- table ----------------
        for (int i = 0; i < vecs.size(); i++) begin
            load    = vecs[i].ld;
            en      = vecs[i].en;
            div_val = vecs[i].div;
            step();
            chk_all($sformatf("vec%0d", i), vecs[i]);
        end

        // ---------------- async reset mid-period, N=8 at cnt=3 ----------------
        load = 1'b1; en = 1'b1; div_val = 8'd8;
        step();
        chk("n8 load cnt", int'(cnt), 0);
        load = 1'b0; div_val = 8'd0;
        step(); step(); step();
        chk("n8 cnt before reset", int'(cnt), 3);
        #2 reset = 1'b1;
        #1;
        chk_all("midreset", mk(0, 0, 0, 0, 0, 0, 0, 0));
        step();
        chk_all("midreset_edge", mk(0, 0, 0, 0, 0, 0, 0, 0));
        reset = 1'b0;
        step();
        chk_all("post_reset e1", mk(0, 1, 0, 0, 0, 1, 1, 0));
        step();
        chk_all("post_reset e2 per=2", mk(0, 1, 0, 1, 1, 0, 1, 1));

        // ---------------- N=1 for 256 pulses, pulse_cnt wrap ----------------
        load = 1'b1; div_val = 8'd1;
        step();
        chk("n1 load no pulse", int'(t_pulse), 0);
        chk("n1 load pc", int'(pulse_cnt), 1);
        load = 1'b0;
        exp_q = 1'b1;
        for (int k = 1; k <= 256; k++) begin
            step();
            exp_q = ~exp_q;
            chk($sformatf("n1 t_pulse %0d", k), int'(t_pulse), 1);
            chk($sformatf("n1 q_div %0d", k), int'(q_div), int'(exp_q));
            chk($sformatf("n1 pc %0d", k), int'(pulse_cnt), (1 + k) % 256);
        end
        // Load with cnt==term (term=0) in RUN: no pulse on that edge
        load = 1'b1; div_val = 8'd1;
        step();
        chk("n1 reload no pulse", int'(t_pulse), 0);
        chk("n1 reload pc hold", int'(pulse_cnt), 1);
        load = 1'b0;
        step();
        chk("n1 after reload pulse", int'(t_pulse), 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/tgen_divider.md
TGEN_DIVIDER -- requirements
Module: tgen_divider

Interface
REQ-001 SHALL have parameter WIDTH, default 8, giving the width of the divide ratio and the phase counter.
REQ-002 SHALL have parameter DEF_DIV, default 2, giving the divide ratio loaded at reset.
REQ-003 clk  input  1  clock; all state updates occur on the falling edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 en  input  1  run enable; 0 pauses counting.
REQ-006 load  input  1  captures div_val on the next falling edge.
REQ-007 div_val  input  WIDTH  new divide ratio N.
REQ-008 t_pulse  output  1  registered one-cycle toggle-enable pulse, once every N cycles; drives the T input of the downstream T flip-flop.
REQ-009 q_div  output  1  internal toggle that flips on every t_pulse, giving a divided-by-2N square wave.
REQ-010 cnt  output  WIDTH  current phase count.
REQ-011 pulse_cnt  output  8  number of t_pulse events, wrapping modulo 256.
REQ-012 busy  output  1  high only in the RUN state.

Function
REQ-013 SHALL implement a three-state FSM: IDLE, RUN, PAUSE.
REQ-014 SHALL hold the ratio register per; term = per-1, except that per=0 and per=1 both give term=0, so a pulse is issued every cycle.
REQ-015 IDLE: cnt holds at 0 and t_pulse=0; en=1 moves the FSM to RUN.
REQ-016 RUN: if cnt==term, then on that edge cnt<=0, t_pulse<=1, q_div<=~q_div and pulse_cnt<=pulse_cnt+1; otherwise cnt<=cnt+1 and t_pulse<=0.
REQ-017 RUN with en=0 moves to PAUSE on that edge: cnt, q_div and pulse_cnt hold, and t_pulse<=0.
REQ-018 PAUSE with en=1 moves to RUN and resumes from the held cnt, with no phase loss.
REQ-019 load=1 has priority over en and over the count update: per<=div_val, cnt<=0, t_pulse<=0; the next state is RUN if en=1, otherwise IDLE; q_div and pulse_cnt hold.
REQ-020 The first pulse after a load with en=1 SHALL be issued on the N-th falling edge after the load edge.
REQ-021 A load issued while RUN is active SHALL abort the current period; no pulse is issued on the load edge, even if cnt==term.
REQ-022 pulse_cnt SHALL wrap from 255 to 0 with no flag.
REQ-023 t_pulse SHALL never be high for two consecutive cycles unless term=0.
REQ-024 Pulse period in RUN SHALL be exactly max(N,1) cycles.
REQ-025 busy SHALL be a decode of the state register only, with no input-dependent combinational path.

Reset
REQ-026 While reset=1, regardless of clk: state=IDLE, per=DEF_DIV, cnt=0, t_pulse=0, q_div=0, pulse_cnt=0, busy=0.
REQ-027 Reset asserted mid-period SHALL abandon the period immediately; after release, the block behaves as freshly reset.
REQ-028 Deassertion SHALL take effect at the first falling edge after reset goes low.

Verification
REQ-029 Reset release, en=1, no load: t_pulse is high on falling edges 2, 4, 6, and so on; q_div reads 1, 0, 1 after each successive pulse.
REQ-030 load with div_val=5 and en=1: pulses appear 5 edges after the load edge and then every 5 edges; cnt sequence is 0,1,2,3,4,0.
REQ-031 div_val=0 and div_val=1: t_pulse is high every cycle; q_div toggles every cycle.
REQ-032 N=4 RUN, en=0 for 3 cycles at cnt=2, then en=1: cnt holds at 2, no pulse during the pause, and the next pulse arrives exactly 2 edges after resume.
REQ-033 Reset asserted between edges at cnt=3 with N=8: all outputs go to 0 immediately, without waiting for a clock edge, and per returns to 2.
REQ-034 N=1 held for 256 cycles: pulse_cnt wraps to 0 after the 256th pulse; load with cnt==term in RUN produces no pulse on that edge.
